// File: rtl/axil_cmd_pkg.sv
// Shared constants for the byte-stream command to AXI-Lite master bridge:
// opcodes, error byte, response sizing and FSM state encodings.
package axil_cmd_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned RSP_BYTES = 5;
    localparam int unsigned RSP_W     = RSP_BYTES * BYTE_W;
    localparam int unsigned CNT_W     = 3;

    localparam logic [7:0] OPC_WRITE = 8'h01;
    localparam logic [7:0] OPC_READ  = 8'h02;
    localparam logic [7:0] RSP_ERR   = 8'hFF;

    localparam logic [2:0] ST_OPCODE = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_WR     = 3'd3;
    localparam logic [2:0] ST_BRESP  = 3'd4;
    localparam logic [2:0] ST_RD     = 3'd5;
    localparam logic [2:0] ST_RDATA  = 3'd6;
    localparam logic [2:0] ST_RSP    = 3'd7;

endpackage

// File: rtl/axil_cmd_master.sv
// Byte-stream command interpreter driving a single-outstanding AXI-Lite master;
// each command yields a short response byte stream.
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [7:0]            s_cmd_tdata,
    input  logic                  s_cmd_tvalid,
    output logic                  s_cmd_tready,
    output logic [7:0]            m_rsp_tdata,
    output logic                  m_rsp_tvalid,
    input  logic                  m_rsp_tready,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    logic [2:0]            state_q, state_nxt;
    logic [1:0]            idx_q, idx_nxt;
    logic                  op_rd_q, op_rd_nxt;
    logic [31:0]           addr_q, addr_nxt;
    logic [DATA_WIDTH-1:0] data_q, data_nxt;
    logic [RSP_W-1:0]      rsp_q, rsp_nxt;
    logic [CNT_W-1:0]      rsp_left_q, rsp_left_nxt;
    logic                  cmd_rdy_q, cmd_rdy_nxt;
    logic                  rsp_vld_q, rsp_vld_nxt;
    logic                  awvalid_q, awvalid_nxt;
    logic                  wvalid_q, wvalid_nxt;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_nxt;
    logic                  bready_q, bready_nxt;
    logic                  arvalid_q, arvalid_nxt;
    logic                  rready_q, rready_nxt;
    logic                  cmd_fire, aw_ok, w_ok;

    // Next-state and next-output logic; every output is the flop of its _nxt.
    always_comb begin
        state_nxt    = state_q;
        idx_nxt      = idx_q;
        op_rd_nxt    = op_rd_q;
        addr_nxt     = addr_q;
        data_nxt     = data_q;
        rsp_nxt      = rsp_q;
        rsp_left_nxt = rsp_left_q;
        awvalid_nxt  = awvalid_q;
        wvalid_nxt   = wvalid_q;
        cmd_fire     = s_cmd_tvalid && cmd_rdy_q;
        aw_ok        = !awvalid_q || m_axil_awready;
        w_ok         = !wvalid_q || m_axil_wready;

        case (state_q)
            ST_OPCODE: begin
                if (cmd_fire) begin
                    idx_nxt = 2'd0;
                    if (s_cmd_tdata == OPC_WRITE || s_cmd_tdata == OPC_READ) begin
                        op_rd_nxt = (s_cmd_tdata == OPC_READ);
                        state_nxt = ST_ADDR;
                    end else begin
                        rsp_nxt      = RSP_W'(RSP_ERR);
                        rsp_left_nxt = CNT_W'(1);
                        state_nxt    = ST_RSP;
                    end
                end
            end
            ST_ADDR: begin
                if (cmd_fire) begin
                    addr_nxt[{idx_q, 3'b000} +: BYTE_W] = s_cmd_tdata;
                    idx_nxt = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_nxt = op_rd_q ? ST_RD : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (cmd_fire) begin
                    data_nxt[{idx_q, 3'b000} +: BYTE_W] = s_cmd_tdata;
                    idx_nxt = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        state_nxt   = ST_WR;
                    end
                end
            end
            ST_WR: begin
                // AW and W complete independently; leave once both are done.
                if (awvalid_q && m_axil_awready) awvalid_nxt = 1'b0;
                if (wvalid_q && m_axil_wready)   wvalid_nxt  = 1'b0;
                if (aw_ok && w_ok)               state_nxt   = ST_BRESP;
            end
            ST_BRESP: begin
                if (m_axil_bvalid) begin
                    rsp_nxt      = RSP_W'({6'b0, m_axil_bresp});
                    rsp_left_nxt = CNT_W'(1);
                    state_nxt    = ST_RSP;
                end
            end
            ST_RD: begin
                if (m_axil_arready) state_nxt = ST_RDATA;
            end
            ST_RDATA: begin
                if (m_axil_rvalid) begin
                    rsp_nxt      = RSP_W'({6'b0, m_axil_rresp, m_axil_rdata});
                    rsp_left_nxt = CNT_W'(RSP_BYTES);
                    state_nxt    = ST_RSP;
                end
            end
            ST_RSP: begin
                // Response bytes shift out LSB-first.
                if (m_rsp_tready) begin
                    rsp_nxt      = rsp_q >> BYTE_W;
                    rsp_left_nxt = rsp_left_q - CNT_W'(1);
                    if (rsp_left_q == CNT_W'(1)) state_nxt = ST_OPCODE;
                end
            end
            default: state_nxt = ST_OPCODE;
        endcase

        cmd_rdy_nxt = (state_nxt == ST_OPCODE) || (state_nxt == ST_ADDR) || (state_nxt == ST_DATA);
        bready_nxt  = (state_nxt == ST_BRESP);
        arvalid_nxt = (state_nxt == ST_RD);
        rready_nxt  = (state_nxt == ST_RDATA);
        rsp_vld_nxt = (state_nxt == ST_RSP);
        wstrb_nxt   = wvalid_nxt ? '1 : '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_OPCODE;
            idx_q      <= 2'd0;
            op_rd_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_q      <= '0;
            rsp_left_q <= '0;
            cmd_rdy_q  <= 1'b1;
            rsp_vld_q  <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            wstrb_q    <= '0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            idx_q      <= idx_nxt;
            op_rd_q    <= op_rd_nxt;
            addr_q     <= addr_nxt;
            data_q     <= data_nxt;
            rsp_q      <= rsp_nxt;
            rsp_left_q <= rsp_left_nxt;
            cmd_rdy_q  <= cmd_rdy_nxt;
            rsp_vld_q  <= rsp_vld_nxt;
            awvalid_q  <= awvalid_nxt;
            wvalid_q   <= wvalid_nxt;
            wstrb_q    <= wstrb_nxt;
            bready_q   <= bready_nxt;
            arvalid_q  <= arvalid_nxt;
            rready_q   <= rready_nxt;
        end
    end

    assign s_cmd_tready   = cmd_rdy_q;
    assign m_rsp_tdata    = rsp_q[BYTE_W-1:0];
    assign m_rsp_tvalid   = rsp_vld_q;
    assign m_axil_awaddr  = ADDR_WIDTH'(addr_q);
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = data_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = ADDR_WIDTH'(addr_q);
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
- ADDR_WIDTH, 32, AXI-Lite address width.
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all logic on its rising edge.
- rstn  in  1  reset; synchronous, active-low.
- s_cmd_tdata  in  8  command byte stream.
- s_cmd_tvalid  in  1  command byte valid.
- s_cmd_tready  out  1  command byte accepted.
- m_rsp_tdata  out  8  response byte stream.
- m_rsp_tvalid  out  1  response byte valid.
- m_rsp_tready  in  1  response sink ready.
- m_axil_aw*, w*, b*, ar*, r*  (standard AXI-Lite master channel set: awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arprot, arvalid, arready, rdata, rresp, rvalid, rready)  widths per ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH; these ports connect as an additional interconnect slave port.

Function
REQ-003 The block SHALL run a single FSM with the states OPCODE, ADDR, DATA, WR, BRESP, RD, RDATA, RSP.
REQ-004 s_cmd_tready SHALL be 1 exactly in OPCODE, ADDR and DATA; a byte transfers when tvalid&tready.
REQ-005 In OPCODE, the accepted byte SHALL decode as follows:
- 0x01 -> write, go to ADDR.
- 0x02 -> read, go to ADDR.
- any other value -> load the single response byte 0xFF, go to RSP.
REQ-006 ADDR SHALL accept 4 bytes LSB-first into the address register, using a 2-bit index that wraps 3->0.
- After the 4th byte: write goes to DATA, read goes to RD.
REQ-007 DATA SHALL accept 4 bytes LSB-first into the write-data register, then go to WR.
REQ-008 On entry to WR, awvalid and wvalid SHALL assert together in the same cycle.
- awaddr = address register; wdata = data register; wstrb = 4'hF; awprot = arprot = 3'b000.
REQ-009 In WR, awvalid SHALL drop on the cycle after awready&awvalid, and wvalid on the cycle after wready&wvalid, each independently.
- When both have handshaken (same cycle or different cycles), the FSM SHALL go to BRESP.
REQ-010 BRESP SHALL hold bready=1 until bvalid, then load the response byte {6'b0,bresp} and go to RSP.
REQ-011 RD SHALL hold arvalid=1 with araddr = address register until arready, then go to RDATA.
REQ-012 RDATA SHALL hold rready=1 until rvalid, capture rdata and rresp, then go to RSP.
- The response is 5 bytes: rdata[7:0], [15:8], [23:16], [31:24], then {6'b0,rresp}.
REQ-013 RSP SHALL present response bytes in order with m_rsp_tvalid=1.
- It SHALL advance only on m_rsp_tready, and return to OPCODE after the last byte is accepted.
REQ-014 Each AXI valid SHALL, once asserted, stay asserted with stable payload until its handshake, independent of the ready signals.
REQ-015 At most one AXI transaction SHALL be outstanding; no command byte SHALL be accepted from WR through RSP.
REQ-016 Back-pressure on the response stream SHALL stall in RSP indefinitely with no data loss.
REQ-017 Latency: from the last command byte accepted to the first AXI valid SHALL be exactly 1 cycle.
- From the B or R handshake to m_rsp_tvalid SHALL be exactly 1 cycle.

Reset
REQ-018 With rstn=0 at a clock edge, the FSM SHALL enter OPCODE and the byte index SHALL clear to 0.
REQ-019 After reset, every output SHALL be 0 except s_cmd_tready, which SHALL be 1; the address, data and response registers SHALL clear to 0.
REQ-020 Reset mid-transaction SHALL abandon the transaction and any partial command immediately.
- Interconnect and slaves share rstn, so no AXI protocol cleanup is required.

Structure
REQ-021 The opcodes (0x01, 0x02), the error byte 0xFF and the FSM state encodings SHALL live in a shared package axil_cmd_pkg.
REQ-022 The block SHALL be one module, with no sub-modules.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Write: bytes 01 00 00 00 00 EF BE AD DE -> one AW with 0x00000000 and one W with 0xDEADBEEF, wstrb F; response byte 0x00; RAM word 0 reads back 0xDEADBEEF.
- Read: bytes 02 00 00 00 00 after the write above -> one AR with 0x00000000; response EF BE AD DE 00.
- Decode error: bytes 02 00 00 00 05 (unmapped 0x05000000) -> response 00 00 00 00 03.
- Bad opcode 0x7A -> single response 0xFF, no AXI activity; the next valid command completes normally.
- Channel skew: slave holds awready low 5 cycles while wready is immediate, then m_rsp_tready is held low 10 cycles -> wvalid drops first, awvalid holds 5 cycles, and the response byte stays stable for 10 cycles.
- rstn pulsed low during RDATA -> all AXI valids 0 and s_cmd_tready 1 on the next cycle; a following write/read pair passes.
